lsu_mem_stage: RTL and testbench

- Load/store unit directly downstream of the ALU: takes the ALU result as the effective address and issues one memory access per accepted request.
- Generates byte strobes and lane-replicated store data, and sign- or zero-extends load data.
- Detects misaligned and illegal accesses without touching memory.
- Holds the core stalled (req_ready low) until the access completes; one outstanding access at a time.

---
 rtl/lsu_mem_stage.sv | 181 ++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - load/store unit memory stage: one outstanding access, byte strobes, load extension
module lsu_mem_stage #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          is_load,
  input  logic          is_store,
  input  logic [2:0]    funct3,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          misalign,
  output logic          illegal,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_wstrb,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t          state_q;
  logic            done_q, misalign_q, illegal_q;
  logic            mem_req_q, mem_we_q, is_load_q;
  logic [AW-1:0]   mem_addr_q;
  logic [3:0]      mem_wstrb_q;
  logic [DW-1:0]   mem_wdata_q, rdata_q;
  logic [1:0]      addr_lo_q;
  logic [2:0]      funct3_q;

  logic            accept_d, illegal_d, misalign_d;
  logic [3:0]      st_wstrb_d;
  logic [DW-1:0]   st_wdata_d, ld_data_d;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  // Decode the incoming request: acceptance, fault classification and store lane formatting
  always_comb begin
    accept_d   = req_valid && (state_q == S_IDLE) && (is_load || is_store);
    illegal_d  = 1'b0;
    if (is_load && is_store) begin
      illegal_d = 1'b1;
    end else if (is_load) begin
      illegal_d = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end else begin
      illegal_d = (funct3 > 3'b010);
    end
    // Illegal wins, so misalign is only raised for otherwise legal encodings
    misalign_d = !illegal_d &&
                 (((funct3[1:0] == 2'b01) && addr[0]) ||
                  ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)));
    st_wstrb_d = 4'b0000;
    st_wdata_d = '0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          st_wstrb_d = 4'b0001 << addr[1:0];
          st_wdata_d = {4{wdata[7:0]}};
        end
        2'b01: begin
          st_wstrb_d = addr[1] ? 4'b1100 : 4'b0011;
          st_wdata_d = {2{wdata[15:0]}};
        end
        default: begin
          st_wstrb_d = 4'b1111;
          st_wdata_d = wdata;
        end
      endcase
    end
  end

  // Pick the addressed lane of the returned word and extend it according to the captured funct3
  always_comb begin
    case (addr_lo_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data_d = {{(DW-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data_d = {{(DW-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data_d = {{(DW-8){1'b0}}, ld_byte};
      3'b101:  ld_data_d = {{(DW-16){1'b0}}, ld_half};
      default: ld_data_d = mem_rdata;
    endcase
  end

  // Access sequencer with all outputs registered; IDLE is the only state that takes requests
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      illegal_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      is_load_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      addr_lo_q   <= 2'b00;
      funct3_q    <= 3'b000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            addr_lo_q <= addr[1:0];
            funct3_q  <= funct3;
            is_load_q <= is_load;
            if (illegal_d || misalign_d) begin
              // Faults complete immediately and never reach memory
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              illegal_q  <= illegal_d;
              misalign_q <= misalign_d;
              rdata_q    <= '0;
            end else begin
              state_q     <= S_REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store;
              mem_addr_q  <= {addr[AW-1:2], 2'b00};
              mem_wstrb_q <= st_wstrb_d;
              mem_wdata_q <= st_wdata_d;
            end
          end
        end
        S_REQ: begin
          // Request fields stay frozen until granted; read data here is not ours yet
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (is_load_q) begin
              state_q <= S_WAIT;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            rdata_q <= ld_data_d;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          done_q     <= 1'b0;
          misalign_q <= 1'b0;
          illegal_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign misalign  = misalign_q;
  assign illegal   = illegal_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - directed self-checking bench for lsu_mem_stage
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, is_load, is_store;
  logic        req_ready;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        done, misalign, illegal;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.DW(32), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata),
    .done(done), .rdata(rdata), .misalign(misalign), .illegal(illegal),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; returns in the first cycle after accept
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd;
    step();
    req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    tests++; if ({done, misalign, illegal, mem_req, mem_we} !== 5'b0) begin fails++; $display("FAIL reset_flags got=%b exp=00000", {done, misalign, illegal, mem_req, mem_we}); end
    tests++; if ({rdata, mem_addr, mem_wdata, mem_wstrb} !== 100'b0) begin fails++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", rdata, mem_addr, mem_wdata, mem_wstrb); end
  endtask

  task automatic test_sw();
    issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    tests++; if ({mem_req, mem_we} !== 2'b11) begin fails++; $display("FAIL sw_req got=%b exp=11", {mem_req, mem_we}); end
    tests++; if (mem_addr !== 32'h100) begin fails++; $display("FAIL sw_addr got=%h exp=00000100", mem_addr); end
    tests++; if (mem_wstrb !== 4'b1111) begin fails++; $display("FAIL sw_strb got=%b exp=1111", mem_wstrb); end
    tests++; if (mem_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_wdata got=%h exp=deadbeef", mem_wdata); end
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL sw_busy got=%b exp=0", req_ready); end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    tests++; if ({done, misalign, illegal, mem_req} !== 4'b1000) begin fails++; $display("FAIL sw_done got=%b exp=1000", {done, misalign, illegal, mem_req}); end
    tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL sw_rdata got=%h exp=0", rdata); end
    step();
    tests++; if ({done, req_ready} !== 2'b01) begin fails++; $display("FAIL sw_idle got=%b exp=01", {done, req_ready}); end
  endtask

  task automatic test_sub_word_store();
    logic [2:0]  f3s  [2] = '{3'b000, 3'b001};
    logic [31:0] as   [2] = '{32'h103, 32'h102};
    logic [31:0] wds  [2] = '{32'h000000A5, 32'h00001234};
    logic [3:0]  strb [2] = '{4'b1000, 4'b1100};
    logic [31:0] exw  [2] = '{32'hA5A5A5A5, 32'h12341234};
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, 1'b1, f3s[i], as[i], wds[i]);
      tests++; if (mem_addr !== 32'h100) begin fails++; $display("FAIL st%0d_addr got=%h exp=00000100", i, mem_addr); end
      tests++; if (mem_wstrb !== strb[i]) begin fails++; $display("FAIL st%0d_strb got=%b exp=%b", i, mem_wstrb, strb[i]); end
      tests++; if (mem_wdata !== exw[i]) begin fails++; $display("FAIL st%0d_wdata got=%h exp=%h", i, mem_wdata, exw[i]); end
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL st%0d_done got=%b exp=1", i, done); end
      step();
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] as  [5] = '{32'h203, 32'h203, 32'h202, 32'h200, 32'h200};
    logic [31:0] exr [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 1'b0, f3s[i], as[i], 32'hFFFFFFFF);
      tests++; if ({mem_req, mem_we, mem_wstrb} !== 6'b100000) begin fails++; $display("FAIL ld%0d_req got=%b exp=100000", i, {mem_req, mem_we, mem_wstrb}); end
      tests++; if (mem_addr !== 32'h200) begin fails++; $display("FAIL ld%0d_addr got=%h exp=00000200", i, mem_addr); end
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      tests++; if ({mem_req, done} !== 2'b00) begin fails++; $display("FAIL ld%0d_wait got=%b exp=00", i, {mem_req, done}); end
      mem_rvalid = 1'b1; mem_rdata = 32'h80FF7F01;
      step();
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL ld%0d_done got=%b exp=1", i, done); end
      tests++; if (rdata !== exr[i]) begin fails++; $display("FAIL ld%0d_rdata got=%h exp=%h", i, rdata, exr[i]); end
      step();
      tests++; if ({done, rdata} !== {1'b0, exr[i]}) begin fails++; $display("FAIL ld%0d_hold got=%b/%h exp=0/%h", i, done, rdata, exr[i]); end
    end
  endtask

  task automatic test_faults();
    logic       lds [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic       sts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0] f3s [4] = '{3'b010, 3'b011, 3'b001, 3'b000};
    logic [31:0] as [4] = '{32'h202, 32'h0, 32'h101, 32'h0};
    logic [1:0] exf [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    for (int i = 0; i < 4; i++) begin
      issue(lds[i], sts[i], f3s[i], as[i], 32'h0);
      tests++; if ({done, misalign, illegal} !== {1'b1, exf[i]}) begin fails++; $display("FAIL flt%0d_flags got=%b exp=1%b", i, {done, misalign, illegal}, exf[i]); end
      tests++; if ({mem_req, rdata} !== 33'b0) begin fails++; $display("FAIL flt%0d_nomem got=%b/%h exp=0/0", i, mem_req, rdata); end
      step();
      tests++; if ({done, misalign, illegal, mem_req, req_ready} !== 5'b00001) begin fails++; $display("FAIL flt%0d_after got=%b exp=00001", i, {done, misalign, illegal, mem_req, req_ready}); end
    end
    // A request with neither type bit is not taken
    req_valid = 1'b1; funct3 = 3'b010; addr = 32'h300;
    step();
    req_valid = 1'b0;
    step();
    tests++; if ({req_ready, mem_req, done} !== 3'b100) begin fails++; $display("FAIL notype got=%b exp=100", {req_ready, mem_req, done}); end
  endtask

  task automatic test_stall();
    issue(1'b1, 1'b0, 3'b010, 32'h304, 32'h0);
    for (int i = 0; i < 6; i++) begin
      tests++; if ({mem_req, req_ready, done, mem_wstrb} !== 7'b1000000 || mem_addr !== 32'h304) begin
        fails++; $display("FAIL stall_req%0d got=%b/%h exp=1000000/00000304", i, {mem_req, req_ready, done, mem_wstrb}, mem_addr);
      end
      mem_rvalid = (i == 2);
      mem_rdata  = (i == 2) ? 32'hBAD0BAD0 : 32'h0;
      mem_gnt    = (i == 5);
      step();
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tests++; if ({mem_req, req_ready, done} !== 3'b000) begin fails++; $display("FAIL stall_wait%0d got=%b exp=000", j, {mem_req, req_ready, done}); end
      mem_rvalid = (j == 2);
      mem_rdata  = 32'h11223344;
      step();
    end
    mem_rvalid = 1'b0;
    tests++; if ({done, rdata} !== {1'b1, 32'h11223344}) begin fails++; $display("FAIL stall_done got=%b/%h exp=1/11223344", done, rdata); end
    step();
    tests++; if ({done, req_ready} !== 2'b01) begin fails++; $display("FAIL stall_single got=%b exp=01", {done, req_ready}); end
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if ({req_ready, done, mem_req} !== 3'b100) begin fails++; $display("FAIL rstmid_idle got=%b exp=100", {req_ready, done, mem_req}); end
    mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
    step();
    mem_rvalid = 1'b0;
    tests++; if ({req_ready, done} !== 2'b10) begin fails++; $display("FAIL rstmid_late got=%b exp=10", {req_ready, done}); end
    step();
    tests++; if ({done, rdata} !== 33'b0) begin fails++; $display("FAIL rstmid_quiet got=%b/%h exp=0/0", done, rdata); end
    issue(1'b1, 1'b0, 3'b010, 32'h404, 32'h0);
    tests++; if ({mem_req, mem_addr} !== {1'b1, 32'h404}) begin fails++; $display("FAIL rstmid_req got=%b/%h exp=1/00000404", mem_req, mem_addr); end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_rvalid = 1'b0;
    tests++; if ({done, rdata} !== {1'b1, 32'hCAFEF00D}) begin fails++; $display("FAIL rstmid_new got=%b/%h exp=1/cafef00d", done, rdata); end
    step();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1;
    test_reset();
    test_sw();
    test_sub_word_store();
    test_loads();
    test_faults();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
